// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, bubble, correction-cycle count.
// Used by the issue stage and the ALU correction logic alike.
package alu_pkg;

  localparam logic [2:0] SEL_ADD = 3'b000;
  localparam logic [2:0] SEL_MUL = 3'b001;

  localparam logic [15:0] BUBBLE_A   = 16'h0000;
  localparam logic [15:0] BUBBLE_B   = 16'h0000;
  localparam logic [2:0]  BUBBLE_SEL = SEL_ADD;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GAP
  } iss_state_e;

  // Only the low nibbles of the operands affect the correction count.
  function automatic logic [1:0] corr_cycles(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic [2:0] sel
  );
    logic       e0, e1, ah, al, bh, bl;
    logic [1:0] k;
    e0 = a[0] & b[0];
    e1 = a[1] & b[1];
    ah = a[3] & a[2];
    al = a[1] & a[0];
    bh = b[3] & b[2];
    bl = b[1] & b[0];
    k  = 2'd0;
    case (sel)
      SEL_ADD: begin
        case ({e0, e1})
          2'b00:   k = 2'd0;
          2'b01:   k = 2'd1;
          2'b10:   k = 2'd2;
          default: k = 2'd1;
        endcase
      end
      SEL_MUL: begin
        case ({ah, al, bh, bl})
          4'b0101, 4'b0110, 4'b1001,
          4'b0111, 4'b1101, 4'b1010,
          4'b1011, 4'b1110, 4'b1111:
            k = 2'd1;
          default: k = 2'd0;
        endcase
      end
      default: k = 2'd0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/alu_op_fifo.sv
// Operation FIFO for the ALU issue stage.
// Power-of-two depth, no bypass, occupancy count.
module alu_op_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 39
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [LW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == LW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_q];
  assign level_o = cnt_q;

  // Storage array, written on accepted pushes.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_op_issuer.sv
// Issue stage ahead of the corrected approximate ALU.
// Spaces ops by their correction count and flags final results.
module alu_op_issuer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [15:0]            in_a,
  input  logic [15:0]            in_b,
  input  logic [2:0]             in_sel,
  input  logic [TAG_W-1:0]       in_tag,
  output logic [15:0]            alu_a,
  output logic [15:0]            alu_b,
  output logic [2:0]             alu_sel,
  output logic                   res_valid,
  output logic [TAG_W-1:0]       res_tag,
  output logic [$clog2(DEPTH):0] level
);

  localparam int W = 35 + TAG_W;

  iss_state_e       state_q;
  logic [1:0]       gap_q;
  logic [15:0]      alu_a_q, alu_b_q;
  logic [2:0]       alu_sel_q;
  logic             full, empty, pop;
  logic [W-1:0]     rdata;
  logic [15:0]      ent_a, ent_b;
  logic [2:0]       ent_sel;
  logic [TAG_W-1:0] ent_tag;
  logic [1:0]       k, slot;
  logic [3:0]       sv_q;
  logic [TAG_W-1:0] st_q [4];
  logic             res_valid_q;
  logic [TAG_W-1:0] res_tag_q;

  alu_op_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (in_valid),
    .wdata_i ({in_a, in_b, in_sel, in_tag}),
    .pop_i   (pop),
    .rdata_o (rdata),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  assign in_ready = !full;
  assign ent_a    = rdata[W-1 -: 16];
  assign ent_b    = rdata[W-17 -: 16];
  assign ent_sel  = rdata[TAG_W +: 3];
  assign ent_tag  = rdata[TAG_W-1:0];
  assign k        = corr_cycles(ent_a[3:0], ent_b[3:0], ent_sel);
  assign slot     = k + 2'd1;

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign res_valid = res_valid_q;
  assign res_tag   = res_tag_q;

  // Pop when the ALU is free to take the next op.
  always_comb begin
    pop = 1'b0;
    unique case (state_q)
      ST_IDLE:  pop = !empty;
      ST_ISSUE: pop = !empty && (gap_q == 2'd0);
      ST_GAP:   pop = !empty && (gap_q == 2'd1);
      default:  pop = 1'b0;
    endcase
  end

  // Issue FSM: drive one op, then bubbles for its correction cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      gap_q     <= 2'd0;
      alu_a_q   <= BUBBLE_A;
      alu_b_q   <= BUBBLE_B;
      alu_sel_q <= BUBBLE_SEL;
    end else if (pop) begin
      state_q   <= ST_ISSUE;
      gap_q     <= k;
      alu_a_q   <= ent_a;
      alu_b_q   <= ent_b;
      alu_sel_q <= ent_sel;
    end else begin
      alu_a_q   <= BUBBLE_A;
      alu_b_q   <= BUBBLE_B;
      alu_sel_q <= BUBBLE_SEL;
      unique case (state_q)
        ST_ISSUE: begin
          state_q <= (gap_q == 2'd0) ? ST_IDLE : ST_GAP;
        end
        ST_GAP: begin
          if (gap_q == 2'd1) begin
            state_q <= ST_IDLE;
            gap_q   <= 2'd0;
          end else begin
            gap_q <= gap_q - 2'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Completion line: an op lands in slot k+1 and fires 2+k later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sv_q        <= '0;
      for (int i = 0; i < 4; i++) st_q[i] <= '0;
      res_valid_q <= 1'b0;
      res_tag_q   <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        sv_q[i] <= sv_q[i+1];
        st_q[i] <= st_q[i+1];
      end
      sv_q[3] <= 1'b0;
      st_q[3] <= '0;
      if (pop) begin
        sv_q[slot] <= 1'b1;
        st_q[slot] <= ent_tag;
      end
      res_valid_q <= sv_q[0];
      res_tag_q   <= sv_q[0] ? st_q[0] : '0;
    end
  end

endmodule

// File: tb/tb_alu_op_issuer.sv
// Bench for alu_op_issuer: issue/result timing scoreboard.
// Expected alu_* and res_* per cycle come from a spacing model.
module tb_alu_op_issuer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0, in_b = '0;
  logic [2:0]  in_sel = '0;
  logic [3:0]  in_tag = '0;
  logic [15:0] alu_a, alu_b;
  logic [2:0]  alu_sel;
  logic        res_valid;
  logic [3:0]  res_tag;
  logic [2:0]  level;

  alu_op_issuer #(.DEPTH(4), .TAG_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sel    (in_sel),
    .in_tag    (in_tag),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .res_valid (res_valid),
    .res_tag   (res_tag),
    .level     (level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  sel;
    logic [3:0]  tag;
  } exp_t;

  exp_t ea_q[$];
  exp_t er_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  int   last_issue = -100;
  int   last_k = 0;

  function automatic int k_ref(logic [15:0] a, logic [15:0] b,
                               logic [2:0] sel);
    logic e0, e1;
    logic [3:0] n;
    e0 = a[0] & b[0];
    e1 = a[1] & b[1];
    n  = {a[3] & a[2], a[1] & a[0], b[3] & b[2], b[1] & b[0]};
    if (sel == 3'b000) begin
      if (e1) return 1;
      if (e0) return 2;
      return 0;
    end
    if (sel == 3'b001)
      return (n inside {4'b0101, 4'b0110, 4'b1001, 4'b0111, 4'b1101,
                        4'b1010, 4'b1011, 4'b1110, 4'b1111}) ? 1 : 0;
    return 0;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      checks++;
      if (ea_q.size() > 0 && ea_q[0].cyc <= cyc) begin
        e = ea_q.pop_front();
        if ({alu_a, alu_b, alu_sel} !== {e.a, e.b, e.sel}) begin
          errors++;
          $display("FAIL alu_op cyc=%0d got %h/%h/%0d want %h/%h/%0d",
                   cyc, alu_a, alu_b, alu_sel, e.a, e.b, e.sel);
        end
      end else if ({alu_a, alu_b, alu_sel} !== 35'd0) begin
        errors++;
        $display("FAIL alu_bubble cyc=%0d got %h/%h/%0d want 0/0/0",
                 cyc, alu_a, alu_b, alu_sel);
      end
      checks++;
      if (er_q.size() > 0 && er_q[0].cyc <= cyc) begin
        e = er_q.pop_front();
        if (res_valid !== 1'b1 || res_tag !== e.tag) begin
          errors++;
          $display("FAIL res cyc=%0d got v=%b t=%0d want v=1 t=%0d",
                   cyc, res_valid, res_tag, e.tag);
        end
      end else if (res_valid !== 1'b0 || res_tag !== 4'd0) begin
        errors++;
        $display("FAIL res_idle cyc=%0d got v=%b t=%0d want v=0 t=0",
                 cyc, res_valid, res_tag);
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic [2:0] sel, input logic [3:0] tag,
                      output bit blk);
    exp_t e;
    int   k, iss;
    blk      = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_sel   = sel;
    in_tag   = tag;
    for (int w = 0; w < 50; w++) begin
      if (in_ready) break;
      blk = 1'b1;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout tag=%0d got in_ready=0 want 1", tag);
    end else begin
      k   = k_ref(a, b, sel);
      iss = cyc + 2;
      if (last_issue + 1 + last_k > iss) iss = last_issue + 1 + last_k;
      e.cyc = iss; e.a = a; e.b = b; e.sel = sel; e.tag = tag;
      ea_q.push_back(e);
      e.cyc = iss + 2 + k;
      er_q.push_back(e);
      last_issue = iss;
      last_k     = k;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int w = 0; w < 100; w++) begin
      if (ea_q.size() == 0 && er_q.size() == 0) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (ea_q.size() != 0 || er_q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s got %0d/%0d pending want 0/0",
               name, ea_q.size(), er_q.size());
      ea_q.delete();
      er_q.delete();
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({alu_a, alu_b, alu_sel} !== 35'd0) begin
      errors++;
      $display("FAIL rst_alu got %h/%h/%0d want 0", alu_a, alu_b, alu_sel);
    end
    checks++;
    if (res_valid !== 1'b0 || res_tag !== 4'd0) begin
      errors++;
      $display("FAIL rst_res got %b/%0d want 0/0", res_valid, res_tag);
    end
    checks++;
    if (level !== 3'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_fifo got lvl=%0d rdy=%b want 0/1", level, in_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (level !== 3'd0 || in_ready !== 1'b1 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_rst got lvl=%0d rdy=%b v=%b want 0/1/0",
               level, in_ready, res_valid);
    end
    mon_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_nocorr();
    bit blk;
    send(16'd1, 16'd2, 3'b000, 4'd1, blk);
    checks++;
    if (level !== 3'd1) begin
      errors++;
      $display("FAIL add_level got %0d want 1", level);
    end
    drain("add_nocorr");
  endtask

  task automatic test_add_k2();
    bit blk;
    send(16'd1, 16'd1, 3'b000, 4'd2, blk);
    send(16'd5, 16'd8, 3'b000, 4'd3, blk);
    drain("add_k2");
  endtask

  task automatic test_mul();
    bit blk;
    send(16'd3, 16'd3, 3'b001, 4'd4, blk);
    send(16'd12, 16'd1, 3'b001, 4'd5, blk);
    drain("mul");
  endtask

  task automatic test_fifo_full();
    bit blk, saw_full;
    saw_full = 1'b0;
    for (int i = 0; i < 10; i++) begin
      send(16'd1, 16'd1, 3'b000, 4'(i + 6), blk);
      saw_full |= blk;
    end
    checks++;
    if (!saw_full) begin
      errors++;
      $display("FAIL fifo_full got in_ready never low want low");
    end
    drain("fifo_full");
    checks++;
    if (level !== 3'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_empty got lvl=%0d rdy=%b want 0/1",
               level, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    bit blk;
    for (int i = 0; i < 6; i++)
      send(16'd0, 16'd0, 3'b000, 4'(i), blk);
    drain("stream");
    send(16'd7, 16'h0100, 3'b010, 4'd12, blk);
    send(16'hf, 16'hf, 3'b001, 4'd13, blk);
    send(16'd2, 16'd3, 3'b000, 4'd14, blk);
    drain("mixed");
  endtask

  task automatic test_reset_inflight();
    bit blk;
    send(16'd1, 16'd1, 3'b000, 4'd7, blk);
    send(16'd2, 16'd2, 3'b000, 4'd8, blk);
    send(16'd4, 16'd4, 3'b000, 4'd9, blk);
    checks++;
    if (level !== 3'd2) begin
      errors++;
      $display("FAIL inflight_level got %0d want 2", level);
    end
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    checks++;
    if ({alu_a, alu_b, alu_sel} !== 35'd0 || res_valid !== 1'b0 ||
        res_tag !== 4'd0 || level !== 3'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_rst got %h/%h/%0d v=%b t=%0d lvl=%0d rdy=%b",
               alu_a, alu_b, alu_sel, res_valid, res_tag, level, in_ready);
    end
    ea_q.delete();
    er_q.delete();
    last_issue = -100;
    last_k     = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if (level !== 3'd0) begin
      errors++;
      $display("FAIL rst_level got %0d want 0", level);
    end
    send(16'd1, 16'd2, 3'b000, 4'd10, blk);
    drain("after_rst");
  endtask

  initial begin
    test_reset();
    test_add_nocorr();
    test_add_k2();
    test_mul();
    test_fifo_full();
    test_back_to_back();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_op_issuer.md
# alu_op_issuer

Operand issue stage that sits directly upstream of the corrected approximate ALU (`ALU_correct`). It accepts operations over a valid/ready handshake and buffers them in a small FIFO. It drives `a`/`b`/`sel` into the ALU, spacing operations so that none is issued while the ALU is in a correction sequence. It also reports, cycle-exactly, when each operation's final corrected `y` is on the ALU output, and which tag that result belongs to.

## Interface
- `DEPTH`, 4: operation FIFO entries (power of two, ≥2).
- `TAG_W`, 4: width of the user tag carried with each operation.

- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operation offered.
- `in_ready` out 1: FIFO can accept (`!full`).
- `in_a`, `in_b` in 16: operands.
- `in_sel` in 3: ALU opcode.
- `in_tag` in TAG_W: user tag.
- `alu_a`, `alu_b` out 16: registered, to ALU `a`, `b`.
- `alu_sel` out 3: registered, to ALU `sel`.
- `res_valid` out 1: registered; high in the cycle the ALU `y` holds a final result.
- `res_tag` out TAG_W: tag of that result; 0 when `res_valid` is low.
- `level` out $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- **Handshake.** A transfer occurs on a rising edge with `in_valid && in_ready`.
  - `in_ready` is low when full; there is no bypass when full, even if a pop happens in the same cycle.
  - Push and pop in the same cycle leave `level` unchanged.
- **Bubble.** The bubble is `alu_a=0`, `alu_b=0`, `alu_sel=3'b000`. It needs no correction and is driven whenever no operation is being issued.
- **Correction count k**, computed from the popped entry:
  - `sel=000` (add): let e0=a[0]&b[0] and e1=a[1]&b[1]. {e0,e1} = 00 gives k=0, 01 gives k=1, 10 gives k=2, 11 gives k=1.
  - `sel=001` (mult): let ah=a[3]&a[2], al=a[1]&a[0], bh=b[3]&b[2], bl=b[1]&b[0]. {ah,al,bh,bl} ∈ {0101,0110,1001,0111,1101,1010,1011,1110,1111} gives k=1; otherwise k=0.
  - All other `sel` values: k=0.
- **FSM** (reset state IDLE):
  - IDLE: drive the bubble. If the FIFO is non-empty, pop, load `alu_*`, load `gap` with k, and go to ISSUE.
  - ISSUE: the op is driven for exactly one cycle.
    - If gap=0 and the FIFO is non-empty, pop the next op and stay in ISSUE (back-to-back).
    - If gap=0 and the FIFO is empty, drive the bubble and go to IDLE.
    - If gap>0, drive the bubble and go to GAP.
  - GAP: drive the bubble and decrement `gap`. When `gap` reaches 0, behave as IDLE, i.e. pop if non-empty.
  - The result: the issue spacing is 1+k cycles.
- **Completion scheduler.** A 4-slot (valid, tag) shift line. An op driven in cycle c is inserted so that it fires `res_valid`/`res_tag` in cycle c+2+k. Given the spacing rule, completions are strictly ordered and never collide.

## Timing
- **Reset values:**
  - `alu_a`/`alu_b`/`alu_sel` = bubble.
  - `res_valid`=0, `res_tag`=0.
  - `level`=0, `in_ready`=1 (during and after reset).
  - FSM in IDLE.
- **Issue latency.** An op pushed at edge t is on `alu_*` from cycle t+1 at the earliest, when the FIFO was empty and the FSM was idle.
- **Result latency.** `res_valid` is high in cycle c+2+k relative to the cycle c in which the op is on `alu_*`. This matches ALU `y` being final: one cycle of input buffering, one cycle of result buffering, plus k correction cycles during which `y`=0.
- **Throughput.** Peak is 1 op/cycle when all k=0. With the FIFO full, the minimum `in_ready` low time equals the current gap.
- **Reset mid-operation.** Asserting reset clears everything asynchronously. FIFO contents, in-flight completions and tags are discarded, and no `res_valid` is emitted for them.

## Structure
- **Shared package `alu_pkg`:**
  - opcode localparams (`SEL_ADD=3'b000`, `SEL_MUL=3'b001`);
  - bubble constants;
  - function `corr_cycles(a,b,sel)` returning k (2 bits).
  - This package is also used by the ALU correction logic so that both blocks share one definition.
- **Sub-module `alu_op_fifo`:** synchronous FIFO of width 35+TAG_W with parameter `DEPTH`, full/empty flags and `level`.
- **In this block:** the FSM, the gap counter and the completion scheduler.

## Test plan
- **Add, no correction.** Push add a=1, b=2, tag=1 into an empty block → `alu_*` driven 1 cycle later; `res_valid`/`res_tag`=1 two cycles after that, with `y`=3.
- **Add, k=2.** Add a=1, b=1, tag=2, then add a=5, b=8, tag=3 back-to-back → the second op is driven exactly 3 cycles after the first. `res_valid` fires at c+4 (tag 2) and at c+3+2 (tag 3); `y` equals the exact sums.
- **Mult, k=1 vs k=0.** Mult a=3, b=3 (k=1), then mult a=12, b=1 (k=0) → spacing 2. Results 9 at c+3 and 12 at c+4.
- **FIFO full.** With `DEPTH`=4 and `in_valid` held high with add a=1, b=1 ops → `in_ready` falls after 4 pushes plus the issuing pop, then toggles with a 3-cycle period. No op is lost and the tag order is preserved.
- **Idle/k=0 stream.** Add a=0, b=0 ops continuously → one `res_valid` per cycle after 2-cycle latency; when the FIFO drains, `alu_*` shows the bubble.
- **Reset in flight.** Assert `rst_n`=0 mid-GAP with 2 ops queued → all outputs return to reset values immediately; after release, `level`=0 and no stale `res_valid` appears.
